// File: rtl/score_keeper_if.sv
// Connects the score keeper to its controller, the ball stage and the display:
// ball position and start request in, serve reset, scores and overlay flags out.
interface score_keeper_if;
    logic [9:0] ball_x_pos;
    logic       start;
    logic       ball_rst_n;
    logic [3:0] left_score;
    logic [3:0] right_score;
    logic       point_pulse;
    logic       game_over;
    logic       winner;

    modport master (
        output ball_x_pos, start,
        input  ball_rst_n, left_score, right_score, point_pulse, game_over, winner
    );

    modport slave (
        input  ball_x_pos, start,
        output ball_rst_n, left_score, right_score, point_pulse, game_over, winner
    );
endinterface

// File: rtl/score_keeper.sv
// Pong score keeper: detects misses past either paddle, keeps scores and re-serves the ball.
// Optional SCORE_KEEPER_AUTO_RESTART_EN restarts the game RESTART_DELAY cycles after game over.
module score_keeper #(
    parameter int LEFT_GOAL_X   = 20,
    parameter int RIGHT_GOAL_X  = 620,
    parameter int WRAP_X        = 960,
    parameter int WIN_SCORE     = 9,
    parameter int SERVE_DELAY   = 25000000,
    parameter int CNT_W         = 26,
    parameter int RESTART_DELAY = 100000000
) (
    input  logic          clk,
    input  logic          reset,
    score_keeper_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SERVE, PLAY, GAME_OVER} state_t;

    // The default restart delay does not fit in CNT_W bits, so the counter widens when needed.
    localparam int RESTART_W = $clog2(RESTART_DELAY);
    localparam int CTR_W     = (CNT_W > RESTART_W) ? CNT_W : RESTART_W;

    localparam logic [CTR_W-1:0] SERVE_LAST = CTR_W'(SERVE_DELAY - 1);
    localparam logic [9:0]       LEFT_X     = 10'(LEFT_GOAL_X);
    localparam logic [9:0]       RIGHT_X    = 10'(RIGHT_GOAL_X);
    localparam logic [9:0]       WRAP_XV    = 10'(WRAP_X);
    localparam logic [3:0]       WIN        = 4'(WIN_SCORE);
`ifdef SCORE_KEEPER_AUTO_RESTART_EN
    localparam logic [CTR_W-1:0] RESTART_LAST = CTR_W'(RESTART_DELAY - 1);
`endif

    state_t           state_q, state_d;
    logic [CTR_W-1:0] counter_q, counter_d;
    logic             armed_q, armed_d;
    logic [3:0]       left_q, left_d;
    logic [3:0]       right_q, right_d;
    logic             pulse_q, pulse_d;
    logic             ball_rst_n_q, ball_rst_n_d;
    logic             game_over_q, game_over_d;
    logic             winner_q, winner_d;
    logic             left_miss, right_miss, centre, restart;

    // Wrapped positions (underflow past 0) count as a left miss.
    assign left_miss  = (bus.ball_x_pos <= LEFT_X) || (bus.ball_x_pos >= WRAP_XV);
    assign right_miss = (bus.ball_x_pos >= RIGHT_X) && (bus.ball_x_pos < WRAP_XV);
    assign centre     = (bus.ball_x_pos > LEFT_X) && (bus.ball_x_pos < RIGHT_X);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            counter_q    <= '0;
            armed_q      <= 1'b0;
            left_q       <= 4'd0;
            right_q      <= 4'd0;
            pulse_q      <= 1'b0;
            ball_rst_n_q <= 1'b0;
            game_over_q  <= 1'b0;
            winner_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            armed_q      <= armed_d;
            left_q       <= left_d;
            right_q      <= right_d;
            pulse_q      <= pulse_d;
            ball_rst_n_q <= ball_rst_n_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
        end
    end

    // Every output is computed here as a next value so that all of them are registered.
    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        armed_d      = armed_q;
        left_d       = left_q;
        right_d      = right_q;
        pulse_d      = 1'b0;
        ball_rst_n_d = 1'b0;
        game_over_d  = game_over_q;
        winner_d     = winner_q;
        restart      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    left_d    = 4'd0;
                    right_d   = 4'd0;
                    counter_d = '0;
                    state_d   = SERVE;
                end
            end
            SERVE: begin
                if (counter_q == SERVE_LAST) begin
                    counter_d    = '0;
                    armed_d      = 1'b0;
                    ball_rst_n_d = 1'b1;
                    state_d      = PLAY;
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end
            PLAY: begin
                ball_rst_n_d = 1'b1;
                armed_d      = armed_q | centre;
                counter_d    = '0;
                // Arming prevents a ball still sitting in a goal after the serve from scoring again.
                if (armed_q && (left_miss || right_miss)) begin
                    pulse_d      = 1'b1;
                    ball_rst_n_d = 1'b0;
                    state_d      = SERVE;
                    if (left_miss) begin
                        right_d = right_q + 4'd1;
                        if ((right_q + 4'd1) == WIN) begin
                            state_d     = GAME_OVER;
                            game_over_d = 1'b1;
                            winner_d    = 1'b1;
                        end
                    end else begin
                        left_d = left_q + 4'd1;
                        if ((left_q + 4'd1) == WIN) begin
                            state_d     = GAME_OVER;
                            game_over_d = 1'b1;
                            winner_d    = 1'b0;
                        end
                    end
                end
            end
            GAME_OVER: begin
                restart = bus.start;
`ifdef SCORE_KEEPER_AUTO_RESTART_EN
                if (counter_q == RESTART_LAST) begin
                    restart = 1'b1;
                end else begin
                    counter_d = counter_q + 1'b1;
                end
`endif
                if (restart) begin
                    left_d      = 4'd0;
                    right_d     = 4'd0;
                    counter_d   = '0;
                    game_over_d = 1'b0;
                    state_d     = SERVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ball_rst_n  = ball_rst_n_q;
    assign bus.left_score  = left_q;
    assign bus.right_score = right_q;
    assign bus.point_pulse = pulse_q;
    assign bus.game_over   = game_over_q;
    assign bus.winner      = winner_q;
endmodule
